sample_rate_divider: RTL and testbench

- Sits directly downstream of the 100 MHz core clock generator; runs entirely on that core clock.
- Receives one raw input sample per valid cycle from the input synchronizer.
- Decimates the sample stream by a programmable 24-bit divider (SUMP "set divider" command) and forwards the retained samples, registered, to the trigger/buffer stages.
- Retains one sample out of every (divider+1) valid samples while running.

---
 rtl/sample_rate_divider.sv | 109 ++++++++++
 tb/tb_sample_rate_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_rate_divider.sv
// Sample-rate divider: keeps 1 of every (divider+1) valid samples while running.
// Build with SAMPLE_COUNT_EN defined to add the saturating sampleCount output.
module sample_rate_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wrDivider,
  input  logic [DIV_WIDTH-1:0]  config_data,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  busy
`ifdef SAMPLE_COUNT_EN
  ,
  output logic [31:0]           sampleCount
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  divider_q, divider_d;
  logic [DIV_WIDTH-1:0]  counter_q, counter_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    divider_d = divider_q;
    counter_d = counter_q;
    data_d    = data_q;
    valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        counter_d = '0;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) state_d = IDLE;
        // The cycle that drops run still processes its sample as RUN.
        if (validIn) begin
          if (counter_q == '0) begin
            data_d    = dataIn;
            valid_d   = 1'b1;
            counter_d = divider_q;
          end else begin
            counter_d = counter_q - DIV_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A divider write overrides any reload so the next valid sample is kept.
    if (wrDivider) begin
      divider_d = config_data;
      counter_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      divider_q <= '0;
      counter_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      divider_q <= divider_d;
      counter_q <= counter_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign busy     = (state_q == RUN);

`ifdef SAMPLE_COUNT_EN
  logic [31:0] count_q, count_d;

  // Counts the pulse issued this cycle, so it moves in step with validOut.
  always_comb begin
    count_d = count_q;
    if (wrDivider || (state_q == IDLE && run)) count_d = '0;
    if (valid_d && count_d != '1) count_d = count_d + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign sampleCount = count_q;
`endif

endmodule

// File: tb/tb_sample_rate_divider.sv
// Self-checking bench for sample_rate_divider: directed scenarios plus randomized
// traffic against a sample-index reference model.
module tb_sample_rate_divider;

  localparam int DW = 32;
  localparam int VW = 24;

  logic          clock = 1'b0;
  logic          reset;
  logic          wrDivider;
  logic [VW-1:0] config_data;
  logic          run;
  logic [DW-1:0] dataIn;
  logic          validIn;
  logic [DW-1:0] dataOut;
  logic          validOut;
  logic          busy;
`ifdef SAMPLE_COUNT_EN
  logic [31:0]   sampleCount;
`endif

  sample_rate_divider #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clock       (clock),
    .reset       (reset),
    .wrDivider   (wrDivider),
    .config_data (config_data),
    .run         (run),
    .dataIn      (dataIn),
    .validIn     (validIn),
    .dataOut     (dataOut),
    .validOut    (validOut),
    .busy        (busy)
`ifdef SAMPLE_COUNT_EN
    ,
    .sampleCount (sampleCount)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a valid sample in RUN is kept when its index, counted from the
  // last divider write or RUN entry, is a multiple of (divider+1).
  bit            m_running;
  logic [VW-1:0] m_div;
  longint        m_idx;
  logic [DW-1:0] m_data;
  logic [31:0]   m_cnt;
  int            kept;

  task automatic model_reset();
    m_running = 1'b0;
    m_div     = '0;
    m_idx     = 0;
    m_data    = '0;
    m_cnt     = '0;
  endtask

  task automatic cycle(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic w, input logic [VW-1:0] c);
    bit exp_valid;
    run = r; validIn = v; dataIn = d; wrDivider = w; config_data = c;
    exp_valid = 1'b0;
    if (!m_running) m_idx = 0;
    if (m_running && v) begin
      if (m_idx % (longint'(m_div) + 1) == 0) begin
        exp_valid = 1'b1;
        m_data    = d;
      end
      m_idx++;
    end
    if (w || (!m_running && r)) m_cnt = '0;
    if (exp_valid && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    if (w) begin
      m_div = c;
      m_idx = 0;
    end
    m_running = r;
    if (exp_valid) kept++;
    @(posedge clock);
    #1;
    check("validOut", validOut, exp_valid);
    check("dataOut", dataOut, m_data);
    check("busy", busy, m_running);
`ifdef SAMPLE_COUNT_EN
    check("sampleCount", sampleCount, m_cnt);
`endif
  endtask

  task automatic idle_inputs();
    run = 1'b0; validIn = 1'b0; dataIn = '0; wrDivider = 1'b0; config_data = '0;
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #3 reset = 1'b1;
    #1;
    check("rst_validOut", validOut, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dataOut", dataOut, '0);
    model_reset();
    idle_inputs();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic set_div(input logic [VW-1:0] c);
    cycle(1'b0, 1'b0, '0, 1'b1, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    kept = 0;
    #12;
    check("reset_validOut", validOut, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_dataOut", dataOut, '0);
    @(negedge clock);
    reset = 1'b0;

    // Full rate: divider 0 forwards every sample.
    set_div(24'd0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, DW'(i), 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, '0);

    // Divider 3 with continuous samples.
    set_div(24'd3);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, DW'(32'h10 + i), 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, '0);

    // Divider 2 with validIn gaps.
    set_div(24'd2);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, DW'(32'hA0 + i), 1'b0, '0);
      cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, '0);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, '0);

    // Divider write landing on a valid sample.
    set_div(24'd4);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h100, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h101, 1'b1, 24'd1);
    for (int i = 2; i < 8; i++) cycle(1'b1, 1'b1, DW'(32'h100 + i), 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, '0);

    // Run dropped and raised again; the last RUN cycle still processes its sample.
    set_div(24'd5);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(32'h200 + i), 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h203, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DW'(32'h204 + i), 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h207, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(32'h208 + i), 1'b0, '0);

    // Largest divider: only the first sample is kept until the next write.
    set_div(24'hFF_FFFF);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, DW'(32'h300 + i), 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h3FF, 1'b1, 24'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(32'h400 + i), 1'b0, '0);

    // Asynchronous reset mid-stream, then full-rate forwarding after release.
    set_div(24'd0);
    cycle(1'b1, 1'b1, 32'h500, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h501, 1'b0, '0);
    async_reset();
    cycle(1'b1, 1'b1, 32'h600, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h601, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h602, 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic r, v, w;
      logic [VW-1:0] c;
      r = ($urandom % 16) != 0;
      v = ($urandom % 4) != 0;
      w = ($urandom % 40) == 0;
      c = (($urandom % 4) == 0) ? VW'($urandom_range(0, 40)) : VW'($urandom % 5);
      cycle(r, v, DW'($urandom), w, c);
    end

    if (kept < 20) check("kept_samples_min", 64'(kept), 64'(20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
